// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer and its counters.
package bp_pkg;

   localparam logic [1:0] CNT_SNT = 2'd0;
   localparam logic [1:0] CNT_WNT = 2'd1;
   localparam logic [1:0] CNT_WT  = 2'd2;
   localparam logic [1:0] CNT_ST  = 2'd3;

   localparam int BP_MODE_BTB = 0;
   localparam int BP_MODE_BHT = 1;

   // Tag is held at its widest size (IDX_BITS >= 1); upper bits stay zero.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      logic [1:0]  cnt;
   } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next state of a 2-bit saturating branch history counter.
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] cnt_nxt
);

   always_comb begin
      cnt_nxt = cnt;
      unique case (1'b1)
         taken && cnt != CNT_ST:   cnt_nxt = cnt + 2'd1;
         !taken && cnt != CNT_SNT: cnt_nxt = cnt - 2'd1;
         default:                  cnt_nxt = cnt;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with optional 2-bit counters, looked up in IF and trained from EX.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int MODE     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_if,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        clear,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        mispredict,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = 30 - IDX_BITS;

   bp_entry_t tbl [ENTRIES];

   logic [IDX_BITS-1:0] l_idx;
   logic [IDX_BITS-1:0] u_idx;
   logic [29:0]         l_tag;
   logic [29:0]         u_tag;
   logic                l_hit;
   logic                u_hit;
   logic [1:0]          cnt_nxt;
   logic                unused_pc_lsb;

   assign unused_pc_lsb = ^{pc_if[1:0], upd_pc[1:0]};

   assign l_idx = pc_if[IDX_BITS+1:2];
   assign u_idx = upd_pc[IDX_BITS+1:2];
   assign l_tag = 30'(pc_if[31:32-TAG_W]);
   assign u_tag = 30'(upd_pc[31:32-TAG_W]);

   assign l_hit = tbl[l_idx].valid && (tbl[l_idx].tag == l_tag);
   assign u_hit = tbl[u_idx].valid && (tbl[u_idx].tag == u_tag);

   always_comb begin
      pred_taken = l_hit;
      if (MODE == BP_MODE_BHT)
         pred_taken = l_hit && tbl[l_idx].cnt[1];
      pred_target = pred_taken ? tbl[l_idx].target : pc_if + 32'd4;
   end

   assign mispredict = upd_valid &&
      ((upd_taken != upd_pred_taken) ||
       (upd_taken && (upd_pred_target != upd_target)));

   bp_sat_counter u_cnt (
      .cnt     (tbl[u_idx].cnt),
      .taken   (upd_taken),
      .cnt_nxt (cnt_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
         end
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         if (upd_valid && br_count != '1)
            br_count <= br_count + 32'd1;
         if (mispredict && mispred_count != '1)
            mispred_count <= mispred_count + 32'd1;
         // Clear wins over a same-cycle update; only the table is affected.
         if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
               tbl[i].valid <= 1'b0;
               tbl[i].cnt   <= CNT_WNT;
            end
         end else if (upd_valid) begin
            if (u_hit) begin
               if (upd_taken)
                  tbl[u_idx].target <= upd_target;
               if (MODE == BP_MODE_BHT)
                  tbl[u_idx].cnt <= cnt_nxt;
               else if (!upd_taken)
                  tbl[u_idx].valid <= 1'b0;
            end else if (upd_taken) begin
               tbl[u_idx] <= '{valid: 1'b1, tag: u_tag,
                               target: upd_target, cnt: CNT_WT};
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor in BHT and BTB-only modes.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_if;
   logic        clear;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;

   logic        pt1, pt0, mis1, mis0;
   logic [31:0] tg1, tg0, bc1, bc0, mc1, mc0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   branch_predictor #(.IDX_BITS(6), .MODE(1)) dut (
      .clk(clk), .rst(rst), .pc_if(pc_if),
      .pred_taken(pt1), .pred_target(tg1),
      .clear(clear), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .mispredict(mis1), .br_count(bc1), .mispred_count(mc1)
   );

   branch_predictor #(.IDX_BITS(6), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .pc_if(pc_if),
      .pred_taken(pt0), .pred_target(tg0),
      .clear(clear), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .mispredict(mis0), .br_count(bc0), .mispred_count(mc0)
   );

   typedef struct {
      logic [31:0] pc;
      logic        clr;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utg;
      logic        upt;
      logic [31:0] uptg;
      logic        e_pt;
      logic [31:0] e_tg;
      logic        e_mis;
      logic [31:0] e_bc;
      logic [31:0] e_mc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] pc, input logic clr,
                      input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg,
                      input logic upt, input logic [31:0] uptg,
                      input logic e_pt, input logic [31:0] e_tg,
                      input logic e_mis, input logic [31:0] e_bc,
                      input logic [31:0] e_mc);
      vec_t v;
      v = '{pc, clr, uv, upc, ut, utg, upt, uptg,
            e_pt, e_tg, e_mis, e_bc, e_mc};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      clear = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
      upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic t,
                      input logic [31:0] tg);
      upd_valid = 1; upd_pc = pc; upd_taken = t; upd_target = tg;
      upd_pred_taken = 0; upd_pred_target = pc + 32'd4;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      rst = 1;
      pc_if = 0;
      idle();

      //   pc     clr uv upc   ut utg    upt uptg   pt tg     mis bc mc
      add(32'h100, 0, 0, 0,      0, 0,      0, 0,      0, 32'h104, 0, 0, 0);
      add(32'h100, 0, 1, 32'h100,1, 32'h80, 0, 32'h104,0, 32'h104, 1, 0, 0);
      add(32'h100, 0, 0, 0,      0, 0,      0, 0,      1, 32'h80,  0, 1, 1);
      add(32'h100, 0, 1, 32'h100,0, 0,      1, 32'h80, 1, 32'h80,  1, 1, 1);
      add(32'h100, 0, 0, 0,      0, 0,      0, 0,      0, 32'h104, 0, 2, 2);
      add(32'h100, 0, 1, 32'h100,1, 32'h80, 0, 32'h104,0, 32'h104, 1, 2, 2);
      add(32'h100, 0, 1, 32'h100,1, 32'h80, 1, 32'h80, 1, 32'h80,  0, 3, 3);
      add(32'h100, 0, 1, 32'h100,0, 0,      1, 32'h80, 1, 32'h80,  1, 4, 3);
      add(32'h100, 0, 0, 0,      0, 0,      0, 0,      1, 32'h80,  0, 5, 4);
      add(32'h200, 0, 1, 32'h200,1, 32'h40, 0, 32'h204,0, 32'h204, 1, 5, 4);
      add(32'h100, 0, 0, 0,      0, 0,      0, 0,      0, 32'h104, 0, 6, 5);
      add(32'h200, 0, 0, 0,      0, 0,      0, 0,      1, 32'h40,  0, 6, 5);
      add(32'h200, 0, 1, 32'h200,1, 32'h44, 1, 32'h40, 1, 32'h40,  1, 6, 5);
      add(32'h200, 0, 0, 0,      0, 0,      0, 0,      1, 32'h44,  0, 7, 6);
      add(32'h300, 1, 1, 32'h300,1, 32'h500,0, 32'h304,0, 32'h304, 1, 7, 6);
      add(32'h300, 0, 0, 0,      0, 0,      0, 0,      0, 32'h304, 0, 8, 7);
      add(32'h200, 0, 0, 0,      0, 0,      0, 0,      0, 32'h204, 0, 8, 7);
      add(32'h0,   0, 0, 0,      1, 32'h8,  0, 32'h4,  0, 32'h4,   0, 8, 7);

      do_reset();

      foreach (vecs[i]) begin
         @(negedge clk);
         pc_if = vecs[i].pc; clear = vecs[i].clr;
         upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
         upd_taken = vecs[i].ut; upd_target = vecs[i].utg;
         upd_pred_taken = vecs[i].upt;
         upd_pred_target = vecs[i].uptg;
         #1;
         chk($sformatf("v%0d pred_taken", i), 32'(pt1), 32'(vecs[i].e_pt));
         chk($sformatf("v%0d pred_target", i), tg1, vecs[i].e_tg);
         chk($sformatf("v%0d mispredict", i), 32'(mis1), 32'(vecs[i].e_mis));
         chk($sformatf("v%0d br_count", i), bc1, vecs[i].e_bc);
         chk($sformatf("v%0d mispred_count", i), mc1, vecs[i].e_mc);
      end
      @(negedge clk);
      idle();
      #1;
      chk("end br_count", bc1, 32'd8);
      chk("end mispred_count", mc1, 32'd7);

      // BTB-only: hit means taken, a not-taken outcome invalidates.
      do_reset();
      pc_if = 32'h100;
      upd(32'h100, 1, 32'h80);
      #1;
      chk("btb cold pred_taken", 32'(pt0), 32'd0);
      @(negedge clk);
      idle();
      #1;
      chk("btb trained pred_taken", 32'(pt0), 32'd1);
      chk("btb trained target", tg0, 32'h80);
      upd(32'h100, 0, 0);
      @(negedge clk);
      idle();
      #1;
      chk("btb invalid pred_taken", 32'(pt0), 32'd0);
      chk("btb invalid target", tg0, 32'h104);
      chk("btb br_count", bc0, 32'd2);

      // Reset during training discards the table and statistics.
      upd(32'h100, 1, 32'h80);
      @(negedge clk);
      upd(32'h100, 1, 32'h80);
      rst = 1;
      @(negedge clk);
      rst = 0;
      idle();
      #1;
      chk("rst bht pred_taken", 32'(pt1), 32'd0);
      chk("rst bht target", tg1, 32'h104);
      chk("rst btb pred_taken", 32'(pt0), 32'd0);
      chk("rst br_count", bc1, 32'd0);
      chk("rst mispred_count", mc1, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
